// File: rtl/sd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_arb_pkg
// Brief    : Shared types and constants for the two-drive SD port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sd_arb_pkg;

    localparam int          NUM_DRIVES             = 2;
    localparam logic [23:0] SD_ARB_TIMEOUT_DEFAULT = 24'd10_000_000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } sd_arb_state_e;

endpackage : sd_arb_pkg
`default_nettype wire

// File: rtl/sd_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : sd_arb_rr_pick
// Brief    : Combinational two-way round-robin chooser with per-drive mask.
// Revision : 1.0 - initial release
// ============================================================================
module sd_arb_rr_pick
    import sd_arb_pkg::*;
(
    input  logic [NUM_DRIVES-1:0] req_i,
    input  logic                  last_i,
    input  logic [NUM_DRIVES-1:0] mask_i,
    output logic                  valid_o,
    output logic                  winner_o
);

    logic [NUM_DRIVES-1:0] elig;

    always_comb begin
        elig     = req_i & ~mask_i;
        valid_o  = |elig;
        winner_o = 1'b0;
        // On a tie the drive that did not own the port last time wins.
        if (&elig) begin
            winner_o = ~last_i;
        end else begin
            winner_o = elig[1];
        end
    end

endmodule : sd_arb_rr_pick
`default_nettype wire

// File: rtl/sd_drive_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sd_drive_arbiter
// Brief    : Grants the single SD block port to one floppy track loader for a
//            whole track transfer and routes ack/buffer traffic to the owner.
//            Optional ack watchdog enabled by defining SD_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sd_drive_arbiter
    import sd_arb_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = SD_ARB_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req_lba0,
    input  logic [31:0] req_lba1,
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_wr,
    output logic [1:0]  req_ack,
    output logic [1:0]  req_buff_wr,
    input  logic [7:0]  req_buff_din0,
    input  logic [7:0]  req_buff_din1,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    output logic        busy,
    output logic        owner,
    output logic [1:0]  timeout_err
);

    sd_arb_state_e         state_q;
    logic                  owner_q;
    logic                  last_q;
    logic [31:0]           sd_lba_q;
    logic                  sd_rd_q;
    logic                  sd_wr_q;
    logic                  busy_q;

    logic [NUM_DRIVES-1:0] req_any;
    logic [NUM_DRIVES-1:0] mask;
    logic                  pick_valid;
    logic                  pick_winner;
    logic                  tmo_hit;

    logic                  own_rd;
    logic                  own_wr;
    logic [31:0]           own_lba;
    logic                  win_rd;
    logic                  win_wr;
    logic [31:0]           win_lba;

    assign req_any = req_rd | req_wr;

    sd_arb_rr_pick u_pick (
        .req_i    (req_any),
        .last_i   (last_q),
        .mask_i   (mask),
        .valid_o  (pick_valid),
        .winner_o (pick_winner)
    );

    assign own_rd  = req_rd[owner_q];
    assign own_wr  = req_wr[owner_q];
    assign own_lba = owner_q ? req_lba1 : req_lba0;
    assign win_rd  = req_rd[pick_winner];
    assign win_wr  = req_wr[pick_winner];
    assign win_lba = pick_winner ? req_lba1 : req_lba0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            sd_lba_q <= 32'd0;
            sd_rd_q  <= 1'b0;
            sd_wr_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sd_rd_q <= 1'b0;
                    sd_wr_q <= 1'b0;
                    if (pick_valid) begin
                        state_q  <= OWN;
                        busy_q   <= 1'b1;
                        owner_q  <= pick_winner;
                        sd_lba_q <= win_lba;
                        sd_rd_q  <= win_rd & ~win_wr;
                        sd_wr_q  <= win_wr;
                    end
                end
                OWN: begin
                    // A pending ack keeps the grant even after the request drops.
                    if (tmo_hit || (!own_rd && !own_wr && !sd_ack)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        last_q  <= owner_q;
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                    end else begin
                        sd_lba_q <= own_lba;
                        sd_rd_q  <= own_rd & ~own_wr;
                        sd_wr_q  <= own_wr;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    sd_rd_q <= 1'b0;
                    sd_wr_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] tmo_cnt_q;
    logic        ack_q;
    logic [1:0]  mask_q;
    logic [1:0]  tmo_err_q;
    logic        ack_rise;

    assign ack_rise = sd_ack & ~ack_q;
    // Fires on the edge where the counter would reach the limit.
    assign tmo_hit  = (state_q == OWN) && !ack_rise &&
                      (tmo_cnt_q == (TIMEOUT_CYCLES - 24'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= 24'd0;
            ack_q     <= 1'b0;
            mask_q    <= 2'b00;
            tmo_err_q <= 2'b00;
        end else begin
            ack_q     <= sd_ack;
            tmo_err_q <= 2'b00;
            if ((state_q == IDLE) || ack_rise) begin
                tmo_cnt_q <= 24'd0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 24'd1;
            end
            mask_q <= mask_q & req_any;
            if (tmo_hit) begin
                tmo_err_q[owner_q] <= 1'b1;
                mask_q[owner_q]    <= 1'b1;
            end
        end
    end

    assign mask        = mask_q;
    assign timeout_err = tmo_err_q;
`else
    logic [23:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
    assign mask           = 2'b00;
    assign timeout_err    = 2'b00;
`endif

    always_comb begin
        req_ack     = 2'b00;
        req_buff_wr = 2'b00;
        sd_buff_din = 8'd0;
        if (state_q == OWN) begin
            req_ack[owner_q]     = sd_ack;
            req_buff_wr[owner_q] = sd_buff_wr;
            sd_buff_din          = owner_q ? req_buff_din1 : req_buff_din0;
        end
    end

    assign sd_lba = sd_lba_q;
    assign sd_rd  = sd_rd_q;
    assign sd_wr  = sd_wr_q;
    assign busy   = busy_q;
    assign owner  = owner_q;

endmodule : sd_drive_arbiter
`default_nettype wire

// File: tb/tb_sd_drive_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_drive_arbiter
// Brief    : Self-checking bench for sd_drive_arbiter (grant scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_drive_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] req_lba0, req_lba1;
    logic [1:0]  req_rd, req_wr;
    logic [1:0]  req_ack, req_buff_wr;
    logic [7:0]  req_buff_din0, req_buff_din1;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack, sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic        busy, owner;
    logic [1:0]  timeout_err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        own;
        logic [31:0] lba;
    } grant_t;

    grant_t sb[$];
    grant_t g;

    sd_drive_arbiter #(.TIMEOUT_CYCLES(24'd100)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_lba0      (req_lba0),
        .req_lba1      (req_lba1),
        .req_rd        (req_rd),
        .req_wr        (req_wr),
        .req_ack       (req_ack),
        .req_buff_wr   (req_buff_wr),
        .req_buff_din0 (req_buff_din0),
        .req_buff_din1 (req_buff_din1),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_ack        (sd_ack),
        .sd_buff_wr    (sd_buff_wr),
        .sd_buff_din   (sd_buff_din),
        .busy          (busy),
        .owner         (owner),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pop the next expected grant and compare owner/lba at the current time.
    task automatic sb_check(input string tag);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got owner=%0d lba=%0d", tag, owner, sd_lba);
        end else begin
            g = sb.pop_front();
            if (owner !== g.own || sd_lba !== g.lba) begin
                errors++;
                $display("FAIL %s: got owner=%0d lba=%0d want owner=%0d lba=%0d",
                         tag, owner, sd_lba, g.own, g.lba);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_lba0 = 32'd0; req_lba1 = 32'd0; req_rd = 2'b00; req_wr = 2'b00;
        req_buff_din0 = 8'd0; req_buff_din1 = 8'd0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
        tick; tick;
        reset = 1'b0;
        checks++;
        if ({sd_rd, sd_wr, busy, owner} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl: got rd/wr/busy/owner=%b want 0000", {sd_rd, sd_wr, busy, owner});
        end
        checks++;
        if (sd_lba !== 32'd0 || timeout_err !== 2'b00) begin
            errors++;
            $display("FAIL reset_lba_err: got lba=%0d err=%b want 0/00", sd_lba, timeout_err);
        end
        checks++;
        if ({req_ack, req_buff_wr, sd_buff_din} !== 12'd0) begin
            errors++;
            $display("FAIL reset_route: got ack=%b bwr=%b din=%h want 0", req_ack, req_buff_wr, sd_buff_din);
        end
    endtask

    task automatic test_single_read;
        req_lba0 = 32'd65; req_rd = 2'b01;
        sb.push_back('{own: 1'b0, lba: 32'd65});
        tick;
        checks++;
        if (sd_rd !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_grant: got rd=%b busy=%b want 1/1", sd_rd, busy);
        end
        sb_check("read_grant_lba");
        for (int k = 0; k < 13; k++) begin
            if (k > 0) sb_check("read_lba_track");
            sd_ack = 1'b1; #1;
            checks++;
            if (req_ack !== 2'b01) begin
                errors++;
                $display("FAIL read_ack_hi: got %b want 01", req_ack);
            end
            tick;
            sd_ack = 1'b0; #1;
            checks++;
            if (req_ack !== 2'b00) begin
                errors++;
                $display("FAIL read_ack_lo: got %b want 00", req_ack);
            end
            if (k < 12) begin
                req_lba0 = 32'(66 + k);
                sb.push_back('{own: 1'b0, lba: 32'(66 + k)});
                tick;
            end else begin
                req_rd = 2'b00;
                tick;
                checks++;
                if (busy !== 1'b0 || sd_rd !== 1'b0) begin
                    errors++;
                    $display("FAIL read_release: got busy=%b rd=%b want 0/0", busy, sd_rd);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL read_sb_drain: got %0d entries want 0", sb.size());
        end
    endtask

    task automatic test_tie;
        reset = 1'b1; tick; reset = 1'b0;
        req_lba0 = 32'd100; req_lba1 = 32'd200; req_rd = 2'b11;
        sb.push_back('{own: 1'b0, lba: 32'd100});
        sb.push_back('{own: 1'b1, lba: 32'd200});
        tick;
        sb_check("tie_first");
        sd_ack = 1'b1; tick;
        sd_ack = 1'b0; req_rd = 2'b10; tick;
        checks++;
        if (busy !== 1'b0 || sd_rd !== 1'b0) begin
            errors++;
            $display("FAIL tie_gap: got busy=%b rd=%b want 0/0", busy, sd_rd);
        end
        tick;
        sb_check("tie_second");
        checks++;
        if (sd_rd !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tie_second_rd: got rd=%b busy=%b want 1/1", sd_rd, busy);
        end
        req_rd = 2'b00; tick;
    endtask

    task automatic test_round_robin;
        req_lba0 = 32'd300; req_lba1 = 32'd400; req_rd = 2'b01;
        tick;
        req_rd = 2'b11; tick;
        checks++;
        if (owner !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rr_hold: got owner=%b busy=%b want 0/1", owner, busy);
        end
        req_rd = 2'b10; tick;
        req_rd = 2'b11;
        sb.push_back('{own: 1'b1, lba: 32'd400});
        tick;
        sb_check("rr_next_owner");
        req_rd = 2'b00; tick;
    endtask

    task automatic test_write;
        req_lba1 = 32'd500; req_buff_din0 = 8'h5A; req_buff_din1 = 8'hA5; req_wr = 2'b10;
        tick;
        checks++;
        if (sd_wr !== 1'b1 || sd_rd !== 1'b0 || owner !== 1'b1 || sd_buff_din !== 8'hA5) begin
            errors++;
            $display("FAIL wr_grant: got wr=%b rd=%b owner=%b din=%h want 1/0/1/a5",
                     sd_wr, sd_rd, owner, sd_buff_din);
        end
        sd_buff_wr = 1'b1; sd_ack = 1'b1; #1;
        checks++;
        if (req_buff_wr !== 2'b10 || req_ack !== 2'b10) begin
            errors++;
            $display("FAIL wr_route: got bwr=%b ack=%b want 10/10", req_buff_wr, req_ack);
        end
        tick;
        sd_buff_wr = 1'b0; sd_ack = 1'b0; req_rd = 2'b10;
        tick;
        checks++;
        if (sd_wr !== 1'b1 || sd_rd !== 1'b0) begin
            errors++;
            $display("FAIL wr_rdwr: got wr=%b rd=%b want 1/0", sd_wr, sd_rd);
        end
        req_rd = 2'b00; req_wr = 2'b00;
        tick;
        checks++;
        if (busy !== 1'b0 || sd_buff_din !== 8'h00) begin
            errors++;
            $display("FAIL wr_release: got busy=%b din=%h want 0/00", busy, sd_buff_din);
        end
    endtask

    task automatic test_late_ack;
        int held;
        req_lba0 = 32'd600; req_rd = 2'b01;
        tick;
        sd_ack = 1'b1; req_rd = 2'b10;
        held = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (busy === 1'b1 && owner === 1'b0) held++;
        end
        checks++;
        if (held != 4) begin
            errors++;
            $display("FAIL late_ack_hold: got %0d owned cycles want 4", held);
        end
        sd_ack = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL late_ack_release: got busy=%b want 0", busy);
        end
        tick;
        checks++;
        if (busy !== 1'b1 || owner !== 1'b1) begin
            errors++;
            $display("FAIL late_ack_next: got busy=%b owner=%b want 1/1", busy, owner);
        end
        req_rd = 2'b00; tick;
    endtask

    task automatic test_reset_mid;
        req_lba0 = 32'd65; req_rd = 2'b01;
        tick;
        for (int k = 0; k < 6; k++) begin
            sd_ack = 1'b1; tick;
            sd_ack = 1'b0; req_lba0 = 32'(66 + k); tick;
        end
        sb.push_back('{own: 1'b0, lba: 32'd71});
        sb_check("mid_sector6");
        reset = 1'b1;
        tick;
        checks++;
        if (sd_rd !== 1'b0 || busy !== 1'b0 || owner !== 1'b0 || sd_lba !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: got rd=%b busy=%b owner=%b lba=%0d want 0/0/0/0",
                     sd_rd, busy, owner, sd_lba);
        end
        reset = 1'b0; req_rd = 2'b00;
        tick;
    endtask

`ifdef SD_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        req_lba0 = 32'd700; req_rd = 2'b01;
        tick;
        n = 0;
        while (n < 200 && timeout_err === 2'b00) begin
            tick;
            n++;
        end
        checks++;
        if (n != 100 || timeout_err !== 2'b01 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got cycle=%0d err=%b busy=%b want 100/01/0", n, timeout_err, busy);
        end
        tick; tick;
        checks++;
        if (timeout_err !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_mask: got err=%b busy=%b want 00/0", timeout_err, busy);
        end
        req_rd = 2'b00; tick;
        req_rd = 2'b01; tick;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_unmask: got busy=%b want 1", busy);
        end
        req_rd = 2'b00; tick;
    endtask
`else
    task automatic test_hold;
        int bad;
        req_lba0 = 32'd700; req_rd = 2'b01;
        tick;
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            tick;
            if (busy !== 1'b1 || timeout_err !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_no_timeout: got %0d bad cycles want 0", bad);
        end
        req_rd = 2'b00; tick;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_single_read;
        test_tie;
        test_round_robin;
        test_write;
        test_late_ack;
        test_reset_mid;
`ifdef SD_ARB_TIMEOUT_EN
        test_timeout;
`else
        test_hold;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sd_drive_arbiter
`default_nettype wire
